sdram_cmd_shifter: RTL and testbench
====================================

SDRAM_CMD_SHIFTER -- requirements
Module: sdram_cmd_shifter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3, number of chained-in-parallel 74595 serial lanes (minimum 3, 8 bits each).
REQ-002 SHALL have parameter SR_DIV, default 1, clk cycles per half-period of every generated strobe (minimum 1).
REQ-003 SHALL have parameter MODE_REG, default 13'h0220, value for LOAD_MODE in the init sequence (BL1, sequential, CL2, single write).
REQ-004 SHALL have parameter INIT_WAIT, default 200, NOP sd_clk pulses issued before init PRECHARGE.
REQ-005 One clock; reset is synchronous and active-high: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1, cmd_ready  out  1: command handshake.
REQ-007 cmd  in  3: 0 NOP, 1 ACTIVE, 2 READ, 3 WRITE, 4 PRECHARGE, 5 AUTO_REFRESH, 6 LOAD_MODE, 7 BURST_TERM.
REQ-008 addr  in  13; ba  in  2; dqm  in  2; repeat_n  in  8 (NOP sd_clk pulses appended after the command).
REQ-009 aux  in  8*(NUM_LANES-3): raw bits for lanes 3 and up.
REQ-010 ser  out  NUM_LANES; srclk  out  1; rclk  out  1; sd_clk  out  1; init_done  out  1.

Function
REQ-011 Frame bits Q_A..Q_H per lane SHALL be: lane0 = addr4, addr12, addr11, addr9, addr8, addr7, addr6, addr5; lane1 = ba0, 0, addr3, addr2, addr1, addr0, addr10, ba1; lane2 = dqm0, dqm1, cke, csb, rasb, casb, web, 0; lane k>=3 = aux[8*(k-3) +: 8], with bit 0 driven to Q_A.
REQ-012 Encoding (csb, rasb, casb, web) SHALL be: NOP 1111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE 0000, BURST_TERM 0110.
REQ-013 cke SHALL be 1 in every frame after reset except frames issued before init_done.
REQ-014 cmd_ready SHALL be 1 only in IDLE with init_done=1; all inputs SHALL be captured on the cmd_valid && cmd_ready cycle and ignored otherwise.
REQ-015 States SHALL be: IDLE, SHIFT, LATCH, CLK_HI, CLK_LO, and with the macro defined also INIT.
REQ-016 SHIFT SHALL emit 8 bits per lane, Q_H first and Q_A last; each bit SHALL be held on ser for SR_DIV cycles with srclk=0, then SR_DIV cycles with srclk=1.
REQ-017 LATCH SHALL drive rclk=1 for SR_DIV cycles, then drive rclk=0.
REQ-018 Each sd_clk pulse SHALL be SR_DIV cycles high followed by SR_DIV cycles low; the command frame SHALL get exactly one pulse.
REQ-019 If repeat_n = R > 0, the block SHALL then shift and latch a NOP frame (cke=1, other fields 0) and issue R sd_clk pulses.
REQ-020 Accept-to-cmd_ready latency SHALL be 19*D cycles for R = 0, and 36*D + 2*D*R cycles for R > 0, where D = SR_DIV.
REQ-021 Strobe counter and bit counter SHALL wrap only at their terminal counts; a repeat_n value of 255 SHALL produce exactly 255 pulses.

Reset
REQ-022 During rst, and on the cycle after it, outputs SHALL be: ser=0, srclk=0, rclk=0, sd_clk=0, cmd_ready=0, init_done=0.
REQ-023 rst asserted mid-frame SHALL abort immediately to the reset state with no rclk or sd_clk pulse emitted afterwards.

Configuration
REQ-024 Macro SDRAM_INIT_SEQ_EN, when defined, SHALL make the block run INIT after reset, in this order:
- NOP frame with cke=0, one pulse;
- NOP frame with cke=1, INIT_WAIT pulses;
- PRECHARGE with addr10=1, plus 2 NOP pulses;
- two rounds of AUTO_REFRESH, each plus 8 NOP pulses;
- LOAD_MODE with addr=MODE_REG, ba=0, plus 2 NOP pulses.
init_done SHALL then be set to 1.
REQ-025 Without SDRAM_INIT_SEQ_EN, init_done SHALL become 1 on the first cycle after rst deasserts, and cmd_ready SHALL follow on that same cycle.

Verification
REQ-026 SR_DIV=1, ACTIVE ba=2 addr=0x1ABC R=0 -> 8 srclk rising edges, then one rclk pulse, then one sd_clk pulse; the decoded 74595 model outputs show ACTIVE ba=2 addr=0x1ABC; cmd_ready returns 19 cycles after accept.
REQ-027 SR_DIV=2, WRITE with addr10=1 and R=3 -> the SDRAM model logs a write with auto-precharge followed by 3 NOP clocks; cmd_ready returns 84 cycles after accept.
REQ-028 cmd_valid held high while busy with changing fields -> only the fields present at the accept cycle are issued; no frame is dropped or duplicated.
REQ-029 rst pulsed at bit 4 of SHIFT -> no rclk or sd_clk edge occurs afterwards; the next command is issued correctly.
REQ-030 With SDRAM_INIT_SEQ_EN, INIT_WAIT=4 -> the SDRAM model sees PRECHARGE all, 2 AUTO_REFRESH, and a mode register write of 0x220 with no timing violations; then init_done=1.
REQ-031 NUM_LANES=4, aux=0xA5 -> lane 3 model Q_A..Q_H read 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/sdram_cmd_shifter.sv
// sdram_cmd_shifter: serialises SDRAM command frames into NUM_LANES parallel
// 74595 shift registers (srclk/rclk), then clocks the SDRAM via sd_clk.
// One frame = 8 bits per lane (Q_H shifted first), one rclk latch, then N
// sd_clk pulses. A command gets one pulse; repeat_n > 0 appends a NOP frame
// carrying repeat_n pulses.
// Optional feature macro: SDRAM_INIT_SEQ_EN runs the power-up sequence
// (CKE low NOP, INIT_WAIT NOPs, PRECHARGE all, 2x AUTO_REFRESH, LOAD_MODE)
// before init_done is raised. INIT_WAIT must be at least 1.
// With NUM_LANES == 3 the aux port is a single ignored bit.
module sdram_cmd_shifter #(
  parameter int          NUM_LANES = 3,
  parameter int          SR_DIV    = 1,
  parameter logic [12:0] MODE_REG  = 13'h0220,
  parameter int          INIT_WAIT = 200,
  localparam int         AUX_W     = (NUM_LANES > 3) ? 8 * (NUM_LANES - 3) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd,
  input  logic [12:0]          addr,
  input  logic [1:0]           ba,
  input  logic [1:0]           dqm,
  input  logic [7:0]           repeat_n,
  input  logic [AUX_W-1:0]     aux,
  output logic [NUM_LANES-1:0] ser,
  output logic                 srclk,
  output logic                 rclk,
  output logic                 sd_clk,
  output logic                 init_done
);

  localparam int DIV_W = (SR_DIV > 1) ? $clog2(SR_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SR_DIV - 1);

  localparam logic [2:0] C_NOP  = 3'd0;
`ifdef SDRAM_INIT_SEQ_EN
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_AREF = 3'd5;
  localparam logic [2:0] C_LMR  = 3'd6;
`endif

  typedef logic [NUM_LANES-1:0][7:0] frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_CLK_HI,
    S_CLK_LO
`ifdef SDRAM_INIT_SEQ_EN
    , S_INIT
`endif
  } state_e;

  // {csb, rasb, casb, web}
  function automatic logic [3:0] cmd_enc(input logic [2:0] c);
    case (c)
      3'd0:    cmd_enc = 4'b1111;
      3'd1:    cmd_enc = 4'b0011;
      3'd2:    cmd_enc = 4'b0101;
      3'd3:    cmd_enc = 4'b0100;
      3'd4:    cmd_enc = 4'b0010;
      3'd5:    cmd_enc = 4'b0001;
      3'd6:    cmd_enc = 4'b0000;
      default: cmd_enc = 4'b0110;
    endcase
  endfunction

  // Lanes 0..2 of a frame; byte bit 0 is Q_A, bit 7 is Q_H. Aux lanes left 0.
  function automatic frame_t build_frame(input logic [2:0] c, input logic [12:0] a,
                                         input logic [1:0] b, input logic [1:0] m,
                                         input logic cke);
    frame_t     f;
    logic [3:0] e;
    e    = cmd_enc(c);
    f    = '0;
    f[0] = {a[5], a[6], a[7], a[8], a[9], a[11], a[12], a[4]};
    f[1] = {b[1], a[10], a[0], a[1], a[2], a[3], 1'b0, b[0]};
    f[2] = {1'b0, e[0], e[1], e[2], e[3], cke, m[1], m[0]};
    return f;
  endfunction

  // One bit position taken across all lanes
  function automatic logic [NUM_LANES-1:0] frame_bits(input frame_t f, input logic [2:0] idx);
    logic [NUM_LANES-1:0] r;
    for (int k = 0; k < NUM_LANES; k++) r[k] = f[k][idx];
    return r;
  endfunction

  state_e               state_q;
  logic [DIV_W-1:0]     div_q;
  logic                 phase_q;     // 0: srclk low half, 1: srclk high half
  logic [2:0]           bit_q;
  logic [15:0]          pulses_q;    // sd_clk pulses left for the current frame
  logic [7:0]           nrep_q;      // pulses for the trailing NOP frame
  logic                 follow_q;    // trailing NOP frame still to be sent
  frame_t               frame_q;
  logic [NUM_LANES-1:0] ser_q;
  logic                 srclk_q, rclk_q, sd_clk_q, cmd_ready_q, init_done_q;

  logic   div_end;
  frame_t aux_frm, acc_frame, nop_frame;

  assign div_end   = (div_q == DIV_MAX);
  assign nop_frame = build_frame(C_NOP, '0, '0, '0, 1'b1);
  assign acc_frame = build_frame(cmd, addr, ba, dqm, 1'b1) | aux_frm;

  // Raw aux bits occupy the lanes above the three SDRAM lanes
  generate
    if (NUM_LANES > 3) begin : g_aux
      assign aux_frm = {aux, 24'b0};
    end else begin : g_noaux
      logic unused_aux;
      assign aux_frm    = '0;
      assign unused_aux = ^aux;
    end
  endgenerate

`ifdef SDRAM_INIT_SEQ_EN
  localparam logic [2:0] INIT_LAST = 3'd5;

  logic [2:0]  init_step_q;
  frame_t      init_frame;
  logic [15:0] init_pulses;
  logic [7:0]  init_rep;

  // Power-up table: frame, its own pulse count, and trailing NOP pulses per step
  always_comb begin
    init_frame  = nop_frame;
    init_pulses = 16'd1;
    init_rep    = 8'd0;
    case (init_step_q)
      3'd0: init_frame = build_frame(C_NOP, '0, '0, '0, 1'b0);
      3'd1: init_pulses = 16'(INIT_WAIT);
      3'd2: begin
        init_frame = build_frame(C_PRE, 13'h0400, '0, '0, 1'b1);
        init_rep   = 8'd2;
      end
      3'd3, 3'd4: begin
        init_frame = build_frame(C_AREF, '0, '0, '0, 1'b1);
        init_rep   = 8'd8;
      end
      3'd5: begin
        init_frame = build_frame(C_LMR, MODE_REG, '0, '0, 1'b1);
        init_rep   = 8'd2;
      end
      default: ;
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MODE_REG, INIT_WAIT[0]};
`endif

  // Frame sequencer: shift, latch, pulse, with all strobes registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      pulses_q    <= '0;
      nrep_q      <= '0;
      follow_q    <= 1'b0;
      frame_q     <= '0;
      ser_q       <= '0;
      srclk_q     <= 1'b0;
      rclk_q      <= 1'b0;
      sd_clk_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
`ifdef SDRAM_INIT_SEQ_EN
      init_step_q <= '0;
`endif
    end else begin
      div_q <= div_end ? '0 : div_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          div_q   <= '0;
          phase_q <= 1'b0;
          bit_q   <= '0;
          if (!init_done_q) begin
`ifdef SDRAM_INIT_SEQ_EN
            init_step_q <= '0;
            state_q     <= S_INIT;
`else
            init_done_q <= 1'b1;
            cmd_ready_q <= 1'b1;
`endif
          end else if (cmd_valid && cmd_ready_q) begin
            frame_q     <= acc_frame;
            ser_q       <= frame_bits(acc_frame, 3'd7);
            srclk_q     <= 1'b0;
            pulses_q    <= 16'd1;
            nrep_q      <= repeat_n;
            follow_q    <= (repeat_n != 8'd0);
            cmd_ready_q <= 1'b0;
            state_q     <= S_SHIFT;
          end
        end
`ifdef SDRAM_INIT_SEQ_EN
        S_INIT: begin
          div_q    <= '0;
          phase_q  <= 1'b0;
          bit_q    <= '0;
          frame_q  <= init_frame;
          ser_q    <= frame_bits(init_frame, 3'd7);
          srclk_q  <= 1'b0;
          pulses_q <= init_pulses;
          nrep_q   <= init_rep;
          follow_q <= (init_rep != 8'd0);
          state_q  <= S_SHIFT;
        end
`endif
        S_SHIFT: begin
          if (div_end) begin
            if (!phase_q) begin
              phase_q <= 1'b1;
              srclk_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              srclk_q <= 1'b0;
              if (bit_q == 3'd7) begin
                bit_q   <= '0;
                ser_q   <= '0;
                rclk_q  <= 1'b1;
                state_q <= S_LATCH;
              end else begin
                bit_q <= bit_q + 3'd1;
                ser_q <= frame_bits(frame_q, 3'd6 - bit_q);
              end
            end
          end
        end
        S_LATCH: begin
          if (div_end) begin
            rclk_q   <= 1'b0;
            sd_clk_q <= 1'b1;
            state_q  <= S_CLK_HI;
          end
        end
        S_CLK_HI: begin
          if (div_end) begin
            sd_clk_q <= 1'b0;
            state_q  <= S_CLK_LO;
          end
        end
        S_CLK_LO: begin
          if (div_end) begin
            if (pulses_q != 16'd1) begin
              pulses_q <= pulses_q - 16'd1;
              sd_clk_q <= 1'b1;
              state_q  <= S_CLK_HI;
            end else if (follow_q) begin
              frame_q  <= nop_frame;
              ser_q    <= frame_bits(nop_frame, 3'd7);
              pulses_q <= {8'd0, nrep_q};
              follow_q <= 1'b0;
              phase_q  <= 1'b0;
              bit_q    <= '0;
              state_q  <= S_SHIFT;
            end else begin
`ifdef SDRAM_INIT_SEQ_EN
              if (!init_done_q && init_step_q != INIT_LAST) begin
                init_step_q <= init_step_q + 3'd1;
                state_q     <= S_INIT;
              end else begin
                init_done_q <= 1'b1;
                cmd_ready_q <= 1'b1;
                state_q     <= S_IDLE;
              end
`else
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ser       = ser_q;
  assign srclk     = srclk_q;
  assign rclk      = rclk_q;
  assign sd_clk    = sd_clk_q;
  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sdram_cmd_shifter.sv
// Bench for sdram_cmd_shifter: 74595 lane model + SDRAM command decoder,
// scoreboard queue filled at accept and drained on every sd_clk rise.
module tb_sdram_cmd_shifter;
  localparam int NL = 4;
  localparam int D  = 2;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd;
  logic [12:0]   addr;
  logic [1:0]    ba, dqm;
  logic [7:0]    repeat_n;
  logic [7:0]    aux;
  logic [NL-1:0] ser;
  logic          srclk, rclk, sd_clk, init_done;

  sdram_cmd_shifter #(.NUM_LANES(NL), .SR_DIV(D), .MODE_REG(13'h0220), .INIT_WAIT(IW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .addr(addr), .ba(ba), .dqm(dqm), .repeat_n(repeat_n), .aux(aux), .ser(ser),
    .srclk(srclk), .rclk(rclk), .sd_clk(sd_clk), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] enc_of(input logic [2:0] c);
    case (c)
      3'd0: return 4'b1111;
      3'd1: return 4'b0011;
      3'd2: return 4'b0101;
      3'd3: return 4'b0100;
      3'd4: return 4'b0010;
      3'd5: return 4'b0001;
      3'd6: return 4'b0000;
      default: return 4'b0110;
    endcase
  endfunction

  // {rsvd lane1 Q_B, rsvd lane2 Q_H, cke, csb/rasb/casb/web, ba, addr, dqm, aux}
  function automatic logic [31:0] pk(input logic cke, input logic [3:0] e, input logic [1:0] b,
                                     input logic [12:0] a, input logic [1:0] m, input logic [7:0] x);
    return {2'b00, cke, e, b, a, m, x};
  endfunction

  logic [31:0] exp_q[$];
  logic [NL-1:0][7:0] sr_m = '0;
  logic [NL-1:0][7:0] out_m = '0;
  logic p_srclk = 0, p_rclk = 0, p_sd = 0, p_rst = 0;
  int   srclk_cnt = 0, rclk_rises = 0, sd_rises = 0, hi_cnt = 0;
  int   lat_cnt = 0, lat_exp = 0;
  bit   lat_run = 0;

  task automatic push_nops(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pk(1'b1, 4'b1111, 2'd0, 13'd0, 2'd0, 8'd0));
  endtask

  task automatic push_init();
    exp_q.push_back(pk(1'b0, 4'b1111, 2'd0, 13'd0, 2'd0, 8'd0));
    push_nops(IW);
    exp_q.push_back(pk(1'b1, 4'b0010, 2'd0, 13'h0400, 2'd0, 8'd0));
    push_nops(2);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(1'b1, 4'b0001, 2'd0, 13'd0, 2'd0, 8'd0));
      push_nops(8);
    end
    exp_q.push_back(pk(1'b1, 4'b0000, 2'd0, 13'h0220, 2'd0, 8'd0));
    push_nops(2);
  endtask

  // Monitor: 74595 model, SDRAM decode, scoreboard and latency, sampled at negedge
  always @(negedge clk) begin
    logic [31:0] got;
    logic [12:0] a;
    if (rst) begin
      exp_q.delete();
      lat_run   = 0;
      srclk_cnt = 0;
    end else begin
`ifdef SDRAM_INIT_SEQ_EN
      if (p_rst) push_init();
`endif
      if (lat_run) begin
        lat_cnt++;
        if (cmd_ready) begin
          chk("latency", 64'(lat_cnt), 64'(lat_exp));
          lat_run = 0;
        end
      end
      if (srclk && !p_srclk) begin
        for (int k = 0; k < NL; k++) sr_m[k] = {sr_m[k][6:0], ser[k]};
        srclk_cnt++;
      end
      if (rclk && !p_rclk) begin
        chk("srclk_per_frame", 64'(srclk_cnt), 64'd8);
        srclk_cnt = 0;
        out_m = sr_m;
        rclk_rises++;
      end
      if (sd_clk && !p_sd) begin
        sd_rises++;
        hi_cnt = 1;
        a = {out_m[0][1], out_m[0][2], out_m[1][6], out_m[0][3], out_m[0][4], out_m[0][5],
             out_m[0][6], out_m[0][7], out_m[0][0], out_m[1][2], out_m[1][3], out_m[1][4], out_m[1][5]};
        got = {out_m[1][1], out_m[2][7], out_m[2][2],
               out_m[2][3], out_m[2][4], out_m[2][5], out_m[2][6],
               out_m[1][7], out_m[1][0], a, out_m[2][1], out_m[2][0], out_m[3]};
        chk("pulse_has_exp", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("frame", 64'(got), 64'(exp_q.pop_front()));
      end else if (sd_clk) begin
        hi_cnt++;
      end else if (p_sd) begin
        chk("sd_clk_high", 64'(hi_cnt), 64'(D));
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(pk(1'b1, enc_of(cmd), ba, addr, dqm, aux));
        push_nops(int'(repeat_n));
        lat_exp = (repeat_n == 0) ? 19 * D : 36 * D + 2 * D * int'(repeat_n);
        lat_cnt = -1;
        lat_run = 1;
      end
    end
    p_srclk = srclk;
    p_rclk  = rclk;
    p_sd    = sd_clk;
    p_rst   = rst;
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 25000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
  endtask

  task automatic set_fields(input logic [2:0] c, input logic [12:0] a, input logic [1:0] b,
                            input logic [1:0] m, input logic [7:0] r, input logic [7:0] x);
    cmd = c; addr = a; ba = b; dqm = m; repeat_n = r; aux = x;
  endtask

  task automatic send(input logic [2:0] c, input logic [12:0] a, input logic [1:0] b,
                      input logic [1:0] m, input logic [7:0] r, input logic [7:0] x);
    wait_ready();
    set_fields(c, a, b, m, r, x);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r0, s0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    set_fields(3'd0, 13'd0, 2'd0, 2'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 64'({ser, srclk, rclk, sd_clk, cmd_ready, init_done}), 64'd0);
    rst = 1'b0;
    #4;
    chk("rst_cycle_after", 64'({ser, srclk, rclk, sd_clk, cmd_ready, init_done}), 64'd0);
    @(posedge clk); #1;
`ifdef SDRAM_INIT_SEQ_EN
    chk("ready_low_during_init", 64'(cmd_ready), 64'd0);
    wait_ready();
    chk("init_done", 64'(init_done), 64'd1);
    chk("init_sb_drained", 64'(exp_q.size()), 64'd0);
`else
    chk("init_done_first_cycle", 64'({init_done, cmd_ready}), 64'b11);
`endif

    // ACTIVE bank 2 row 0x1ABC, then write with auto-precharge and 3 NOPs
    send(3'd1, 13'h1ABC, 2'd2, 2'd0, 8'd0, 8'h3C);
    send(3'd3, 13'h0523, 2'd1, 2'd2, 8'd3, 8'h00);
    // Remaining opcodes with varied fields
    send(3'd2, 13'h0FFF, 2'd3, 2'd1, 8'd0, 8'hFF);
    send(3'd4, 13'h0400, 2'd0, 2'd3, 8'd1, 8'h5A);
    send(3'd5, 13'h1001, 2'd2, 2'd0, 8'd2, 8'h81);
    send(3'd6, 13'h0220, 2'd0, 2'd0, 8'd0, 8'h00);
    send(3'd7, 13'h12A5, 2'd1, 2'd3, 8'd0, 8'h7E);
    send(3'd0, 13'h1555, 2'd3, 2'd2, 8'd1, 8'h24);
    // Aux lane bit order
    send(3'd1, 13'h0000, 2'd0, 2'd0, 8'd0, 8'hA5);
    wait_ready();
    chk("lane3_qa_qh", 64'({out_m[3][0], out_m[3][1], out_m[3][2], out_m[3][3],
                            out_m[3][4], out_m[3][5], out_m[3][6], out_m[3][7]}), 64'hA5);
    // Longest trailing NOP burst
    send(3'd2, 13'h0ABC, 2'd1, 2'd1, 8'd255, 8'h01);

    // cmd_valid held while busy with fields churning
    for (int t = 0; t < 2; t++) begin
      wait_ready();
      set_fields(3'd3, 13'h1234 + 13'(t), 2'(t), 2'd1, 8'(t), 8'h10 + 8'(t));
      cmd_valid = 1'b1;
      n = 0;
      @(posedge clk); #1;
      while (!cmd_ready && n < 5000) begin
        set_fields(3'($urandom), 13'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
        @(posedge clk); #1;
        n++;
      end
      set_fields(3'd2, 13'h0F0F, 2'd2, 2'd3, 8'd1, 8'hC3);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end

    // Reset during the shift of bit 4
    send(3'd1, 13'h0555, 2'd1, 2'd0, 8'd2, 8'h11);
    n = 0;
    while (srclk_cnt < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_bit4", 64'(srclk_cnt >= 4), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outs", 64'({ser, srclk, rclk, sd_clk, cmd_ready, init_done}), 64'd0);
    rst = 1'b0;
    r0 = rclk_rises;
    s0 = sd_rises;
    repeat (30) @(posedge clk);
    #1;
    chk("no_rclk_after_rst", 64'(rclk_rises - r0), 64'd0);
    chk("no_sdclk_after_rst", 64'(sd_rises - s0), 64'd0);
    send(3'd3, 13'h1C0D, 2'd3, 2'd1, 8'd1, 8'h99);

    wait_ready();
    repeat (10) @(posedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
